// File: rtl/aether_engine_stream_mem.sv
// Strided N-word read/write task engine for the SDRAM controller port.
// Host data moves over valid/ready streams; reads land in a FWFT FIFO.
module aether_engine_stream_mem #(
  parameter int DataWidth     = 16,
  parameter int AddrWidth     = 25,
  parameter int CountWidth    = 32,
  parameter int ReadFifoDepth = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [AddrWidth-1:0]  start_address_i,
  input  logic [CountWidth-1:0] count_i,
  input  logic [AddrWidth-1:0]  stride_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  input  logic [DataWidth-1:0]  wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DataWidth-1:0]  rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [1:0]            mem_command_o,
  output logic [AddrWidth-1:0]  mem_address_o,
  output logic [DataWidth-1:0]  mem_data_write_o,
  input  logic [DataWidth-1:0]  mem_data_read_i,
  input  logic                  mem_read_valid_i,
  input  logic                  mem_write_done_i
);
  localparam int PW = $clog2(ReadFifoDepth);
  localparam logic [PW:0] LP_DEPTH = ReadFifoDepth[PW:0];

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CMD, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_mode;
  logic                  r_abort;
  logic [AddrWidth-1:0]  r_addr;
  logic [AddrWidth-1:0]  r_stride;
  logic [CountWidth-1:0] r_rem;
  logic [DataWidth-1:0]  r_wdata;

  logic [DataWidth-1:0]  r_mem [ReadFifoDepth];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW:0]           r_cnt;

  logic w_ack;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_space;
  logic w_wr_hs;
  logic w_last;
  logic w_abortable;

  assign w_empty     = (r_cnt == '0);
  assign w_space     = (r_cnt < LP_DEPTH);
  assign w_ack       = r_mode ? mem_write_done_i
                              : mem_read_valid_i;
  assign w_push      = (r_state == S_WAIT) && !r_mode
                       && mem_read_valid_i;
  assign w_pop       = !w_empty && rd_ready_i;
  assign w_wr_hs     = wr_valid_i && wr_ready_o;
  assign w_last      = (r_rem == CountWidth'(1));
  assign w_abortable = (r_state == S_FETCH)
                       || (r_state == S_CMD)
                       || (r_state == S_WAIT);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_mode   <= 1'b0;
      r_abort  <= 1'b0;
      r_addr   <= '0;
      r_stride <= '0;
      r_rem    <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start_i) begin
        r_mode   <= mode_i;
        r_addr   <= start_address_i;
        r_stride <= stride_i;
        r_rem    <= count_i;
        r_abort  <= 1'b0;
      end
      if (w_wr_hs) r_wdata <= wr_data_i;
      if (w_abortable && abort_i) r_abort <= 1'b1;
      if (r_state == S_WAIT && w_ack) begin
        r_rem  <= r_rem - CountWidth'(1);
        r_addr <= r_addr + r_stride;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_i)
          w_next = (count_i == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        if (abort_i)
          w_next = S_DRAIN;
        else if (r_mode ? wr_valid_i : w_space)
          w_next = S_CMD;
      end
      S_CMD: w_next = S_WAIT;
      S_WAIT: begin
        if (w_ack)
          w_next = (w_last || r_abort || abort_i)
                   ? S_DRAIN : S_FETCH;
      end
      S_DRAIN: begin
        if (w_empty) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (r_state != S_IDLE);
    done_o        = (r_state == S_DONE);
    aborted_o     = (r_state == S_DONE) && r_abort;
    // A beat offered alongside abort must stay with the host.
    wr_ready_o    = (r_state == S_FETCH) && r_mode
                    && !abort_i;
    mem_command_o = 2'd0;
    if (r_state == S_CMD)
      mem_command_o = r_mode ? 2'd1 : 2'd2;
  end

  assign mem_address_o    = r_addr;
  assign mem_data_write_o = r_wdata;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= mem_data_read_i;
  end

  assign rd_valid_o = !w_empty;
  assign rd_data_o  = w_empty ? '0 : r_mem[r_rptr];

endmodule

// File: tb/tb_aether_engine_stream_mem.sv
// Directed bench for aether_engine_stream_mem with a
// 3-cycle-ack controller model and stream monitors.
module tb_aether_engine_stream_mem;
  localparam int DW  = 16;
  localparam int AW  = 25;
  localparam int CW  = 32;
  localparam int FD  = 8;
  localparam int ACK = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic          mode_i;
  logic [AW-1:0] start_address_i;
  logic [CW-1:0] count_i;
  logic [AW-1:0] stride_i;
  logic          abort_i;
  logic          busy_o;
  logic          done_o;
  logic          aborted_o;
  logic [DW-1:0] wr_data_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [1:0]    mem_command_o;
  logic [AW-1:0] mem_address_o;
  logic [DW-1:0] mem_data_write_o;
  logic [DW-1:0] mem_data_read_i;
  logic          mem_read_valid_i;
  logic          mem_write_done_i;

  aether_engine_stream_mem #(
    .DataWidth(DW), .AddrWidth(AW),
    .CountWidth(CW), .ReadFifoDepth(FD)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .start_i(start_i), .mode_i(mode_i),
    .start_address_i(start_address_i),
    .count_i(count_i), .stride_i(stride_i),
    .abort_i(abort_i), .busy_o(busy_o),
    .done_o(done_o), .aborted_o(aborted_o),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i),
    .wr_ready_o(wr_ready_o), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .mem_command_o(mem_command_o),
    .mem_address_o(mem_address_o),
    .mem_data_write_o(mem_data_write_o),
    .mem_data_read_i(mem_data_read_i),
    .mem_read_valid_i(mem_read_valid_i),
    .mem_write_done_i(mem_write_done_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_cmd = 0;
  int n_beat = 0;
  int n_done = 0;
  int n_abt = 0;
  int n_bad_abt = 0;
  int n_busy = 0;
  int n_wrdy = 0;
  int n_hs = 0;
  int done_cyc = 0;
  logic done_rdv = 1'b0;

  logic [1:0]    log_cmd  [256];
  logic [AW-1:0] log_addr [256];
  logic [DW-1:0] log_data [256];
  int            log_cyc  [256];
  logic [DW-1:0] beat     [256];
  int            beat_cyc [256];
  int            hs_cyc   [256];

  typedef struct {
    logic                 mode;
    logic [AW-1:0]        sa;
    logic [CW-1:0]        cnt;
    logic [AW-1:0]        str;
    int                   n;
    logic [0:3][AW-1:0]   ea;
    logic [0:3][DW-1:0]   ed;
  } vec_t;

  vec_t vt [5];

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  // Controller model plus output monitors, all sampled mid-cycle.
  initial begin
    int dly;
    logic pend;
    logic [1:0] pc;
    logic [AW-1:0] pa;
    pend = 1'b0;
    dly = 0;
    pc = 2'd0;
    pa = '0;
    mem_read_valid_i = 1'b0;
    mem_write_done_i = 1'b0;
    mem_data_read_i = '0;
    forever begin
      @(negedge clk_i);
      mem_read_valid_i = 1'b0;
      mem_write_done_i = 1'b0;
      if (!rst_ni) begin
        pend = 1'b0;
      end else begin
        if (busy_o) n_busy++;
        if (wr_ready_o) n_wrdy++;
        if (done_o) begin
          n_done++;
          done_cyc = cyc;
          done_rdv = rd_valid_o;
        end
        if (aborted_o) begin
          n_abt++;
          if (!done_o) n_bad_abt++;
        end
        if (rd_valid_o && rd_ready_i && n_beat < 256) begin
          beat[n_beat] = rd_data_o;
          beat_cyc[n_beat] = cyc;
          n_beat++;
        end
        if (pend) begin
          dly--;
          if (dly == 0) begin
            pend = 1'b0;
            if (pc == 2'd2) begin
              mem_read_valid_i = 1'b1;
              mem_data_read_i = pa[15:0] ^ 16'hC3C3;
            end else begin
              mem_write_done_i = 1'b1;
            end
          end
        end
        if (mem_command_o != 2'd0 && n_cmd < 256) begin
          log_cmd[n_cmd] = mem_command_o;
          log_addr[n_cmd] = mem_address_o;
          log_data[n_cmd] = mem_data_write_o;
          log_cyc[n_cmd] = cyc;
          n_cmd++;
          pend = 1'b1;
          pc = mem_command_o;
          pa = mem_address_o;
          dly = ACK;
        end
      end
    end
  end

  // Write stream source: the k-th accepted beat carries 0xA1+k.
  initial begin
    logic hs;
    wr_data_i = 16'hA1;
    forever begin
      @(negedge clk_i);
      hs = rst_ni && wr_valid_i && wr_ready_o;
      if (hs) hs_cyc[n_hs] = cyc;
      @(posedge clk_i);
      #1;
      if (hs) begin
        n_hs++;
        wr_data_i = 16'hA1 + 16'(n_hs);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic start_task(input logic m,
                            input logic [AW-1:0] a,
                            input logic [CW-1:0] c,
                            input logic [AW-1:0] s,
                            output int sc);
    start_i = 1'b1;
    mode_i = m;
    start_address_i = a;
    count_i = c;
    stride_i = s;
    sc = cyc;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int db, input int lim,
                           input string nm);
    int k;
    k = 0;
    while (n_done == db && k < lim) begin
      tick(1);
      k++;
    end
    chk(nm, n_done - db, 1);
  endtask

  task automatic wait_cmds(input int cb, input int n,
                           input int lim);
    int k;
    k = 0;
    while (n_cmd - cb < n && k < lim) begin
      tick(1);
      k++;
    end
  endtask

  initial begin
    int sc, cb, bb, db, ab, hb, bz, wr0, dummy;
    rst_ni = 1'b0;
    start_i = 1'b0;
    mode_i = 1'b0;
    start_address_i = '0;
    count_i = '0;
    stride_i = '0;
    abort_i = 1'b0;
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b1;

    vt[0] = '{1'b0, 25'h100, 32'd4, 25'd1, 4,
              {25'h100, 25'h101, 25'h102, 25'h103}, '0};
    vt[1] = '{1'b1, 25'h1FFFFFE, 32'd3, 25'd2, 3,
              {25'h1FFFFFE, 25'h0, 25'h2, 25'h0},
              {16'hA1, 16'hA2, 16'hA3, 16'h0}};
    vt[2] = '{1'b0, 25'h1FFFFFF, 32'd3, 25'd0, 3,
              {25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF,
               25'h0}, '0};
    vt[3] = '{1'b0, 25'h040, 32'd0, 25'd1, 0, '0, '0};
    vt[4] = '{1'b0, 25'h010, 32'd3, 25'h1000000, 3,
              {25'h010, 25'h1000010, 25'h010, 25'h0}, '0};

    tick(3);
    chk("rst busy", int'(busy_o), 0);
    chk("rst done", int'(done_o), 0);
    chk("rst cmd", int'(mem_command_o), 0);
    chk("rst rd_valid", int'(rd_valid_o), 0);
    chk("rst wr_ready", int'(wr_ready_o), 0);
    chk("rst addr", int'(mem_address_o), 0);
    chk("rst wdata", int'(mem_data_write_o), 0);
    chk("rst rdata", int'(rd_data_o), 0);
    rst_ni = 1'b1;
    tick(2);

    for (int i = 0; i < 5; i++) begin
      cb = n_cmd; bb = n_beat; db = n_done;
      ab = n_abt; hb = n_hs; bz = n_busy;
      wr_valid_i = vt[i].mode;
      start_task(vt[i].mode, vt[i].sa, vt[i].cnt,
                 vt[i].str, sc);
      wait_done(db, 300, $sformatf("v%0d done", i));
      tick(3);
      wr_valid_i = 1'b0;
      chk($sformatf("v%0d ncmd", i), n_cmd - cb, vt[i].n);
      chk($sformatf("v%0d aborted", i), n_abt - ab, 0);
      for (int k = 0; k < vt[i].n; k++) begin
        chk($sformatf("v%0d addr%0d", i, k),
            int'(log_addr[cb+k]), int'(vt[i].ea[k]));
        chk($sformatf("v%0d cmd%0d", i, k),
            int'(log_cmd[cb+k]), vt[i].mode ? 1 : 2);
        if (vt[i].mode) begin
          chk($sformatf("v%0d wdata%0d", i, k),
              int'(log_data[cb+k]), int'(vt[i].ed[k]));
          chk($sformatf("v%0d wlat%0d", i, k),
              log_cyc[cb+k], hs_cyc[hb+k] + 1);
        end else begin
          chk($sformatf("v%0d rdata%0d", i, k),
              int'(beat[bb+k]),
              int'(vt[i].ea[k][15:0] ^ 16'hC3C3));
        end
      end
      if (!vt[i].mode)
        chk($sformatf("v%0d nbeat", i), n_beat - bb,
            vt[i].n);
      if (vt[i].n > 0 && !vt[i].mode)
        chk($sformatf("v%0d rlat", i), log_cyc[cb] - sc, 2);
      if (vt[i].n == 0) begin
        chk("zero done lat", done_cyc - sc, 1);
        chk("zero busy cycles", n_busy - bz, 1);
      end
    end

    // Backpressure: FIFO fills, engine stalls, ignores a restart.
    cb = n_cmd; bb = n_beat; db = n_done;
    rd_ready_i = 1'b0;
    start_task(1'b0, 25'h200, 32'd12, 25'd1, sc);
    tick(80);
    chk("bp stall ncmd", n_cmd - cb, 8);
    chk("bp busy", int'(busy_o), 1);
    chk("bp no done", n_done - db, 0);
    start_task(1'b1, 25'h7, 32'd5, 25'd1, dummy);
    tick(20);
    chk("bp restart ignored", n_cmd - cb, 8);
    rd_ready_i = 1'b1;
    wait_done(db, 300, "bp done");
    tick(2);
    chk("bp ncmd", n_cmd - cb, 12);
    chk("bp nbeat", n_beat - bb, 12);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("bp cmd%0d", k),
          int'(log_cmd[cb+k]), 2);
      chk($sformatf("bp beat%0d", k), int'(beat[bb+k]),
          int'(16'(16'h200 + k) ^ 16'hC3C3));
    end
    chk("bp fifo empty at done", int'(done_rdv), 0);
    chk("bp last beat before done",
        int'(beat_cyc[bb+11] < done_cyc), 1);

    // Abort during the second write's ack wait.
    cb = n_cmd; db = n_done; ab = n_abt; hb = n_hs;
    wr_valid_i = 1'b1;
    start_task(1'b1, 25'h300, 32'd5, 25'd1, sc);
    wait_cmds(cb, 2, 100);
    chk("ab second cmd seen", n_cmd - cb, 2);
    wr0 = n_wrdy;
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    wait_done(db, 100, "ab done");
    tick(3);
    wr_valid_i = 1'b0;
    chk("ab ncmd", n_cmd - cb, 2);
    chk("ab nhs", n_hs - hb, 2);
    chk("ab addr0", int'(log_addr[cb]), 'h300);
    chk("ab addr1", int'(log_addr[cb+1]), 'h301);
    chk("ab data0", int'(log_data[cb]), 'hA4);
    chk("ab data1", int'(log_data[cb+1]), 'hA5);
    chk("ab aborted", n_abt - ab, 1);
    chk("ab aborted with done", n_bad_abt, 0);
    chk("ab wr_ready stays low", n_wrdy - wr0, 0);

    // Reset with 3 words buffered and one read in flight.
    cb = n_cmd;
    rd_ready_i = 1'b0;
    start_task(1'b0, 25'h400, 32'd8, 25'd1, sc);
    wait_cmds(cb, 4, 100);
    chk("rr fourth cmd seen", n_cmd - cb, 4);
    chk("rr rd_valid before", int'(rd_valid_o), 1);
    rst_ni = 1'b0;
    tick(1);
    rst_ni = 1'b1;
    chk("rr rd_valid", int'(rd_valid_o), 0);
    chk("rr busy", int'(busy_o), 0);
    chk("rr cmd", int'(mem_command_o), 0);
    chk("rr done", int'(done_o), 0);
    tick(2);
    cb = n_cmd; bb = n_beat; db = n_done; ab = n_abt;
    rd_ready_i = 1'b1;
    start_task(1'b0, 25'h500, 32'd2, 25'd3, sc);
    wait_done(db, 100, "rr2 done");
    tick(3);
    chk("rr2 ncmd", n_cmd - cb, 2);
    chk("rr2 addr1", int'(log_addr[cb+1]), 'h503);
    chk("rr2 nbeat", n_beat - bb, 2);
    chk("rr2 beat0", int'(beat[bb]), 'h0500 ^ 'hC3C3);
    chk("rr2 beat1", int'(beat[bb+1]), 'h0503 ^ 'hC3C3);
    chk("rr2 aborted", n_abt - ab, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
